// File: rtl/tt_spi_pkg.sv
// -----------------------------------------------------------------------------
// tt_spi_pkg
// Shared definitions for the SPI register responder:
//   - spi_state_t : frame FSM states (IDLE/CMD/DATA/DONE)
//   - REG_*       : register map addresses
//   - PIN_*       : bit positions of the SPI signals on ui_in / uio_*
// -----------------------------------------------------------------------------
package tt_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    localparam logic [1:0] REG_OUT     = 2'd0;
    localparam logic [1:0] REG_SCRATCH = 2'd1;
    localparam logic [1:0] REG_FCNT    = 2'd2;
    localparam logic [1:0] REG_ID      = 2'd3;

    localparam int PIN_SCK  = 0;   // ui_in
    localparam int PIN_CS_N = 1;   // ui_in
    localparam int PIN_MOSI = 2;   // ui_in
    localparam int PIN_MISO = 0;   // uio_out / uio_oe

endpackage

// File: rtl/tt_sync_edge.sv
// -----------------------------------------------------------------------------
// tt_sync_edge
// Multi-flop synchronizer for one asynchronous input, plus single-cycle
// rise/fall pulses derived from the last two synchronized samples.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input
//   o_q      synchronized level
//   o_rise   one-cycle pulse on a synchronized 0->1 transition
//   o_fall   one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module tt_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0   // idle level of the input
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_chain[SYNC_STAGES-1];
    assign o_rise =  r_chain[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_chain[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/tt_spi_reg_responder.sv
// -----------------------------------------------------------------------------
// tt_spi_reg_responder
// Mode-0 SPI responder (oversampled in the clk domain) exposing four 8-bit
// registers. Frame = command byte {W, 5'bx, addr[1:0]} then one data byte,
// both MSB first.
//   reg0 R/W -> uo_out, reg1 R/W scratch, reg2 RO frame counter, reg3 RO ID.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   ena         design select; low behaves as cs_n high
//   ui_in       [0]=sck, [1]=cs_n, [2]=mosi, [7:3] unused
//   uo_out      registered copy of reg0
//   uio_in      unused
//   uio_out     [0]=miso (registered), others 0
//   uio_oe      [0]=selected (registered), others 0
// -----------------------------------------------------------------------------
module tt_spi_reg_responder
    import tt_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // ---------------------------------------------------------------- inputs
    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_cs_n_sync, w_cs_n_rise, w_cs_n_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(ui_in[PIN_SCK]),
        .o_q(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    // cs_n idles high, so reset the chain high to avoid a spurious select.
    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(ui_in[PIN_CS_N]),
        .o_q(w_cs_n_sync), .o_rise(w_cs_n_rise), .o_fall(w_cs_n_fall)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(ui_in[PIN_MOSI]),
        .o_q(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // Select is qualified with ena; its edges come from the registered copy.
    assign w_unused = ^{uio_in, ui_in[7:3], w_sck_sync, w_cs_n_rise, w_cs_n_fall,
                        w_mosi_rise, w_mosi_fall};

    logic w_sel, w_sel_rise;
    logic r_sel_q;

    assign w_sel      = ena & ~w_cs_n_sync;
    assign w_sel_rise = w_sel & ~r_sel_q;

    // ------------------------------------------------------------- registers
    spi_state_t r_state, w_state_next;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift, r_tx_shift, r_cmd;
    logic [7:0] r_reg0, r_reg1, r_frame_cnt;
    logic [7:0] r_uo_out;
    logic       r_miso;

    logic [7:0] w_rx_next, w_rd_data;
    logic       w_last_bit, w_is_read;
    logic       w_bit_tick, w_cmd_done, w_data_done, w_tx_shift, w_miso;

    assign w_rx_next  = {r_rx_shift[6:0], w_mosi_sync};
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_is_read  = ~r_cmd[7];

    // Read data is selected by the address bits of the byte being completed.
    always_comb begin
        w_rd_data = 8'h00;
        case (w_rx_next[1:0])
            REG_OUT:     w_rd_data = r_reg0;
            REG_SCRATCH: w_rd_data = r_reg1;
            REG_FCNT:    w_rd_data = r_frame_cnt;
            REG_ID:      w_rd_data = ID_VALUE;
            default:     w_rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------ FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------ FSM: next state
    // Deselect is checked first so an abort beats any same-cycle sck edge.
    always_comb begin
        w_state_next = r_state;
        if (!w_sel) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_sel_rise)               w_state_next = ST_CMD;
                ST_CMD:  if (w_sck_rise && w_last_bit) w_state_next = ST_DATA;
                ST_DATA: if (w_sck_rise && w_last_bit) w_state_next = ST_DONE;
                ST_DONE:                               w_state_next = ST_DONE;
                default:                               w_state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ FSM: outputs
    always_comb begin
        w_bit_tick  = 1'b0;
        w_cmd_done  = 1'b0;
        w_data_done = 1'b0;
        w_tx_shift  = 1'b0;
        w_miso      = 1'b0;
        case (r_state)
            ST_CMD: begin
                w_bit_tick = w_sel & w_sck_rise;
                w_cmd_done = w_sel & w_sck_rise & w_last_bit;
            end
            ST_DATA: begin
                w_bit_tick  = w_sel & w_sck_rise;
                w_data_done = w_sel & w_sck_rise & w_last_bit;
                // The falling edge right after the command byte must keep the
                // freshly loaded MSB on the line, so no shift while the data
                // bit counter is still 0.
                w_tx_shift  = w_sel & w_sck_fall & w_is_read & (r_bit_cnt != 3'd0);
                w_miso      = w_is_read & r_tx_shift[7];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_cmd       <= 8'h00;
            r_reg0      <= 8'h00;
            r_reg1      <= 8'h00;
            r_frame_cnt <= 8'h00;
            r_uo_out    <= 8'h00;
            r_miso      <= 1'b0;
            r_sel_q     <= 1'b0;
        end else begin
            r_sel_q  <= w_sel;
            r_miso   <= w_miso;
            r_uo_out <= r_reg0;

            if (r_state == ST_IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if (w_bit_tick) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_rx_shift <= w_rx_next;
            end

            if (w_cmd_done) begin
                r_cmd <= w_rx_next;
                if (!w_rx_next[7]) begin
                    r_tx_shift <= w_rd_data;
                end
            end else if (w_tx_shift) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end

            if (w_data_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (r_cmd[7]) begin
                    case (r_cmd[1:0])
                        REG_OUT:     r_reg0 <= w_rx_next;
                        REG_SCRATCH: r_reg1 <= w_rx_next;
                        default:     ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------ pins
    assign uo_out = r_uo_out;

    always_comb begin
        uio_out           = 8'h00;
        uio_oe            = 8'h00;
        uio_out[PIN_MISO] = r_miso;
        uio_oe[PIN_MISO]  = r_sel_q;
    end

endmodule

// File: tb/tb_tt_spi_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_tt_spi_reg_responder
// Host-side SPI driver plus scoreboard for tt_spi_reg_responder. Read frames
// push their expected byte into exp_q; a monitor pops and compares whenever
// the driver publishes a collected MISO byte.
// -----------------------------------------------------------------------------
module tb_tt_spi_reg_responder;

  // ---------------------------------------------------------- clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  logic sck   = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign ui_in  = {5'b00000, mosi, cs_n, sck};
  assign uio_in = 8'h00;

  always #5 clk = ~clk;

  tt_spi_reg_responder #(
    .SYNC_STAGES(2),
    .ID_VALUE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  // ---------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;
  int half     = 8;  // sck half period in clk cycles

  logic [7:0] exp_q[$];
  logic [7:0] rd_byte  = 8'h00;
  logic       rd_valid = 1'b0;
  logic [7:0] mon_exp;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL miso_read: got %02h with no expected entry", rd_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_byte !== mon_exp) begin
          failures++;
          $display("FAIL miso_read: got %02h expected %02h", rd_byte, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 sck period: data set while low, MISO sampled at the rise.
  task automatic sck_cycle(input logic b, output logic m);
    mosi = b;
    wait_clks(half);
    m   = uio_out[0];
    sck = 1'b1;
    wait_clks(half);
    sck = 1'b0;
  endtask

  // Frame with nbits sck periods: <16 aborts, >16 adds trailing clocks.
  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data,
                           input int nbits, output logic [7:0] rd);
    logic [15:0] word;
    logic        m;
    word = {cmd, data};
    rd   = 8'h00;
    cs_n = 1'b0;
    wait_clks(half);
    check8("oe_selected", uio_oe, 8'h01);
    for (int i = 0; i < nbits; i++) begin
      sck_cycle((i < 16) ? word[15-i] : 1'b1, m);
      if (i >= 8 && i < 16) rd[15-i] = m;
    end
    wait_clks(half);
    cs_n = 1'b1;
    wait_clks(2 * half);
    check8("oe_released", uio_oe, 8'h00);
    check8("miso_idle", uio_out, 8'h00);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] r;
    spi_frame(cmd, data, 16, r);
  endtask

  task automatic spi_read(input logic [7:0] cmd, input logic [7:0] exp);
    logic [7:0] r;
    exp_q.push_back(exp);
    spi_frame(cmd, 8'h00, 16, r);
    rd_byte  = r;
    rd_valid = 1'b1;
    wait_clks(1);
    rd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    logic [7:0]  r;
    logic        m;
    logic [15:0] word;

    // reset and idle pins
    rst_n = 1'b0;
    wait_clks(3);
    check8("rst_uo_out", uo_out, 8'h00);
    check8("rst_uio_out", uio_out, 8'h00);
    check8("rst_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    wait_clks(10);
    check8("idle_uo_out", uo_out, 8'h00);
    check8("idle_uio_out", uio_out, 8'h00);
    check8("idle_uio_oe", uio_oe, 8'h00);

    // writes and readback (frame count 0 -> 5)
    spi_write(8'h80, 8'h5A);
    check8("uo_write_reg0", uo_out, 8'h5A);
    spi_write(8'h81, 8'hC3);
    check8("uo_after_reg1_write", uo_out, 8'h5A);
    spi_read(8'h02, 8'h02);
    spi_read(8'h01, 8'hC3);
    spi_read(8'h03, 8'hA5);

    // aborted write: command + 4 data bits
    spi_frame(8'h80, 8'h00, 12, r);
    check8("uo_after_abort", uo_out, 8'h5A);
    spi_read(8'h02, 8'h05);

    // ignored command bits, write to read-only counter
    spi_read(8'h7E, 8'h06);
    spi_write(8'h82, 8'hFF);
    spi_read(8'h02, 8'h08);

    // trailing sck cycles after a completed frame
    spi_frame(8'h81, 8'h3C, 24, r);
    check8("uo_after_extra_sck", uo_out, 8'h5A);
    spi_read(8'h01, 8'h3C);
    spi_read(8'h00, 8'h5A);

    // counter wrap: 12 frames so far, 244 more reach 256 -> 0
    half = 4;
    for (int i = 0; i < 244; i++) begin
      spi_write(8'h81, 8'(i));
    end
    half = 8;
    spi_read(8'h02, 8'h00);
    spi_read(8'h01, 8'hF3);

    // ena dropped mid-frame
    word = {8'h80, 8'h11};
    cs_n = 1'b0;
    wait_clks(half);
    for (int i = 0; i < 12; i++) sck_cycle(word[15-i], m);
    ena = 1'b0;
    wait_clks(1);
    check8("oe_ena_drop", uio_oe, 8'h00);
    for (int i = 12; i < 16; i++) sck_cycle(word[15-i], m);
    cs_n = 1'b1;
    wait_clks(2 * half);
    ena = 1'b1;
    wait_clks(2 * half);
    check8("uo_after_ena_drop", uo_out, 8'h5A);
    spi_read(8'h02, 8'h02);

    // asynchronous reset in the middle of a read of reg0
    word = {8'h00, 8'h00};
    cs_n = 1'b0;
    wait_clks(half);
    for (int i = 0; i < 10; i++) sck_cycle(word[15-i], m);
    #2;
    rst_n = 1'b0;
    #1;
    check8("rst_mid_uo_out", uo_out, 8'h00);
    check8("rst_mid_uio_out", uio_out, 8'h00);
    check8("rst_mid_uio_oe", uio_oe, 8'h00);
    cs_n = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(10);
    check8("uo_after_reset", uo_out, 8'h00);
    spi_read(8'h00, 8'h00);
    spi_read(8'h02, 8'h01);

    // drain scoreboard
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) wait_clks(1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_spi_reg_responder.md
Name: tt_spi_reg_responder

Overview:
- Chip-side counterpart to the bench/host that drives the pins of toplevel_module.
- A mode-0 SPI responder on the dedicated input pins, with MISO returned on a bidirectional pin.
- Exposes four 8-bit registers; register 0 drives uo_out directly.
- All SPI inputs are oversampled in the clk domain. No SPI clock is used as a clock.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (legal range 2..3)
- ID_VALUE, 8'hA5, constant returned by register 3

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design-select; when low, treated as cs_n high
- ui_in  input  8  [0]=sck, [1]=cs_n, [2]=mosi, [7:3] unused
- uo_out  output  8  contents of register 0
- uio_in  input  8  unused
- uio_out  output  8  [0]=miso, [7:1]=0
- uio_oe  output  8  8'h01 while selected, else 8'h00

Behaviour:
- Reset values (rst_n low, asynchronous):
  - uo_out=0, uio_out=0, uio_oe=0
  - reg0=0, reg1=0, frame_cnt=0
  - FSM=IDLE, bit counter=0, shift registers=0
- Input synchronizers:
  - sck, cs_n and mosi each pass through a SYNC_STAGES-flop synchronizer.
  - sck/cs_n edges are detected from the last two synchronized samples.
  - sel = ena & ~cs_n_sync.
- Timing requirement on the host: SCK high and low phases each ≥ SYNC_STAGES+2 clk cycles.
- Frame format (MSB first):
  - Command byte: [7]=W (1=write), [6:2] ignored, [1:0]=addr.
  - Followed by one data byte.
- Sampling and shifting:
  - MOSI is sampled on synchronized sck rising edges.
  - MISO changes on synchronized sck falling edges.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE -> CMD on sel rising. Bit counter cleared.
  - CMD: shift in 8 bits. On the 8th rising edge:
    - latch cmd and go to DATA.
    - if read, load tx_shift with read data and drive miso=tx_shift[7] from the next clk.
  - DATA (write): shift in 8 bits. On the 8th rising edge, commit to the addressed register, increment frame_cnt, go to DONE.
  - DATA (read): on each sck falling edge, shift tx_shift left and drive the new MSB. On the 8th rising edge, increment frame_cnt and go to DONE.
  - DONE: further sck edges are ignored; miso=0.
  - Any state -> IDLE when sel falls (cs_n high or ena low). A partial frame is discarded: no commit, no frame_cnt increment.
- Register map:
  - 0: R/W, drives uo_out; uo_out updates on the clk after commit.
  - 1: R/W scratch.
  - 2: RO frame_cnt, 8-bit, wraps 255->0. Writes are ignored but still count as a completed frame.
  - 3: RO, returns ID_VALUE.
- Read data is captured at load time. A read of reg 2 returns the count before the current frame is counted.
- miso is 0 in IDLE, CMD, DONE and during write frames.
- uio_oe[0] = sel, registered. uio_out[0] = miso, registered.
- If a sck edge and the sel deassert are seen in the same clk, the abort wins.

Decomposition:
- Shared package tt_spi_pkg holds:
  - FSM state typedef (IDLE/CMD/DATA/DONE)
  - register address constants REG_OUT=0, REG_SCRATCH=1, REG_FCNT=2, REG_ID=3
  - pin index constants for sck/cs_n/mosi/miso
- One sub-module: tt_sync_edge. It holds the SYNC_STAGES synchronizer plus a rise/fall pulse output and is instantiated for sck and cs_n. mosi uses the synchronizer only.

Test Plan:
- Reset, then idle pins (cs_n=1, ena=1) -> uo_out=8'h00, uio_oe=8'h00, uio_out=8'h00.
- Write frame 0x80,0x5A with SCK half-period 8 clk -> uo_out=8'h5A within 2 clk of the 16th rising edge; uio_oe=8'h01 only while cs_n low.
- Write 0x81,0xC3, then read 0x01 -> MISO returns 0xC3. Read 0x03 -> 0xA5. Read 0x02 -> 8'h02, reflecting the two prior completed frames.
- Abort: write 0x80 then 4 data bits, raise cs_n -> uo_out unchanged; a subsequent reg 2 read shows no increment.
- 256 completed write frames to reg 1 -> a subsequent reg 2 read returns 8'h00 (wrap). Extra 8 SCK cycles after a frame leave all registers unchanged.
- Drop ena mid-frame -> uio_oe=0 next clk, frame discarded. Assert rst_n low mid-frame -> all outputs 0 immediately, reg0=0.
